// File: rtl/sum_acc_pkg.sv
// Shared types and helpers for the frame accumulator: FSM state encoding
// and the frame-length clamp applied when a frame starts.
package sum_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t;

  // A zero length still means one sample; anything above the capacity is capped.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0)
      return 1;
    else if (len > max_len)
      return max_len;
    else
      return len;
  endfunction

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Unsigned ACC_WIDTH add with carry-out, optionally clamping to all-ones on carry.
module sat_add #(
  parameter int ACC_WIDTH = 16,
  parameter int SATURATE  = 0
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);

  logic [ACC_WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[ACC_WIDTH];
  // An all-ones accumulator plus anything non-zero carries again, so saturation is sticky.
  assign sum  = ((SATURATE != 0) && ovf) ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulate-and-dump of adder results: sums a frame of len samples, then
// holds the total with a sticky overflow flag until downstream takes it.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int ACC_WIDTH  = 16,
  parameter  int MAX_LEN    = 16,
  parameter  int SATURATE   = 0,
  localparam int CNT_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH:0]   in_sum,
  input  logic [CNT_W-1:0]      len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_ovf
);

  generate
    if (ACC_WIDTH < DATA_WIDTH + 1) begin : g_width_check
      $error("sum_accumulator: ACC_WIDTH must be at least DATA_WIDTH+1");
    end
  endgenerate

  acc_state_t           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_add;
  logic [ACC_WIDTH-1:0] in_ext;
  logic                 add_ovf;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     target;
  logic [CNT_W-1:0]     target_new;
  logic                 ovf;
  logic                 in_acc;
  logic                 out_acc_hs;

  assign in_ext     = ACC_WIDTH'(in_sum);
  assign target_new = CNT_W'(clamp_len(32'(len), MAX_LEN));
  assign in_acc     = in_valid && in_ready;
  assign out_acc_hs = out_valid && out_ready;

  sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_add (
    .a   (acc),
    .b   (in_ext),
    .sum (acc_add),
    .ovf (add_ovf)
  );

  // in_ready/out_valid are registered alongside the state so that neither
  // handshake side sees a combinational path from the other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      target    <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (in_acc) begin
            acc    <= in_ext;
            count  <= CNT_W'(1);
            ovf    <= 1'b0;
            target <= target_new;
            if (target_new == CNT_W'(1)) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_acc) begin
            acc   <= acc_add;
            count <= count + CNT_W'(1);
            if (add_ovf)
              ovf <= 1'b1;
            if (count + CNT_W'(1) == target) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_acc_hs) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Drives three accumulators (16-bit wrap, 10-bit saturate, 10-bit wrap) with one
// shared stream and checks each frame total against a plain-arithmetic model.
module tb_sum_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [8:0] in_sum;
  logic [4:0] len;
  logic       out_ready;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [15:0] acc0;
  logic [9:0]  acc1, acc2;
  logic [4:0]  cnt0, cnt1, cnt2;
  logic        of0, of1, of2;

  int tests = 0;
  int fails = 0;

  sum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .MAX_LEN(16), .SATURATE(0)) dut_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_sum(in_sum), .len(len),
    .out_valid(ov0), .out_ready(out_ready), .out_acc(acc0), .out_count(cnt0), .out_ovf(of0));

  sum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(10), .MAX_LEN(16), .SATURATE(1)) dut_s10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_sum(in_sum), .len(len),
    .out_valid(ov1), .out_ready(out_ready), .out_acc(acc1), .out_count(cnt1), .out_ovf(of1));

  sum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(10), .MAX_LEN(16), .SATURATE(0)) dut_w10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_sum(in_sum), .len(len),
    .out_valid(ov2), .out_ready(out_ready), .out_acc(acc2), .out_count(cnt2), .out_ovf(of2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Frame total as the spec defines it: wrap is modulo 2^w, saturate is min(total, 2^w-1).
  function automatic int exp_acc(input longint tot, input int w, input bit sat);
    longint lim;
    lim = longint'(1) << w;
    if (sat) return int'((tot >= lim) ? lim - 1 : tot);
    return int'(tot % lim);
  endfunction

  function automatic int frame_len(input int l);
    if (l == 0) return 1;
    if (l > 16) return 16;
    return l;
  endfunction

  task automatic chk_hs(input string tag, input logic [2:0] vld, input logic [2:0] rdy);
    chk({tag, " out_valid"}, {ov2, ov1, ov0}, vld);
    chk({tag, " in_ready"},  {ir2, ir1, ir0}, rdy);
  endtask

  task automatic chk_out(input string tag, input int cnt, input longint tot);
    logic [4:0] c5;
    c5 = 5'(cnt);
    chk_hs(tag, 3'b111, 3'b000);
    chk({tag, " count"}, {cnt2, cnt1, cnt0}, {c5, c5, c5});
    chk({tag, " acc16"}, acc0, exp_acc(tot, 16, 1'b0));
    chk({tag, " acc10sat"}, acc1, exp_acc(tot, 10, 1'b1));
    chk({tag, " acc10wrap"}, acc2, exp_acc(tot, 10, 1'b0));
    chk({tag, " ovf"}, {of2, of1, of0}, {tot >= 1024, tot >= 1024, tot >= 65536});
  endtask

  task automatic chk_zero(input string tag);
    chk_hs(tag, 3'b000, 3'b000);
    chk({tag, " acc"}, {acc2, acc1, acc0}, 0);
    chk({tag, " count"}, {cnt2, cnt1, cnt0}, 0);
    chk({tag, " ovf"}, {of2, of1, of0}, 0);
  endtask

  // Called at 1 time unit after an edge; presents one sample until accepted.
  task automatic push(input int v, input int lv);
    int k;
    in_valid = 1'b1;
    in_sum   = 9'(v);
    len      = 5'(lv);
    k = 0;
    while (!ir0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) chk("push timeout in_ready", ir0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sum   = 9'($urandom_range(0, 511));
  endtask

  task automatic run_frame(input string tag, input int lv, input int vals[$], input int len_mid,
                           input int hold, input bit gaps);
    int n;
    int v;
    longint tot;
    n   = frame_len(lv);
    tot = 0;
    for (int i = 0; i < n; i++) begin
      v = (i < vals.size()) ? vals[i] : int'($urandom_range(0, 511));
      tot += v;
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      push(v, (i == 0) ? lv : len_mid);
      if (i < n - 1) chk_hs({tag, " mid"}, 3'b000, 3'b111);
    end
    chk_out(tag, n, tot);
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      in_sum   = 9'($urandom_range(0, 511));
      @(posedge clk); #1;
      chk_out({tag, " hold"}, n, tot);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_hs({tag, " after accept"}, 3'b000, 3'b111);
  endtask

  initial begin
    int q[$];
    int lv;
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; len = '0; out_ready = 1'b0;
    #3;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk_hs("post reset", 3'b000, 3'b111);

    q = {10, 20, 30, 40};
    run_frame("basic", 4, q, 4, 0, 1'b0);
    q = {510, 510};
    run_frame("carry", 2, q, 2, 0, 1'b0);
    q = {511, 511, 511};
    run_frame("overflow", 3, q, 3, 0, 1'b0);
    q = {100, 200};
    run_frame("backpressure", 2, q, 2, 5, 1'b0);
    q = {7};
    run_frame("len1", 1, q, 1, 0, 1'b0);

    push(1, 4);
    push(2, 4);
    #3 rst = 1'b1;
    #1 chk_zero("async reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk_hs("reset recover", 3'b000, 3'b111);
    q = {1, 2};
    run_frame("after reset", 2, q, 2, 0, 1'b0);

    q = {5};
    run_frame("len0", 0, q, 0, 0, 1'b0);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(1);
    run_frame("len20", 20, q, 20, 0, 1'b0);
    q = {3, 4, 5};
    run_frame("len change low", 3, q, 1, 0, 1'b0);
    run_frame("len change high", 3, q, 15, 0, 1'b0);

    for (int f = 0; f < 20; f++) begin
      q.delete();
      lv = int'($urandom_range(0, 20));
      if (f[0]) for (int i = 0; i < 16; i++) q.push_back(int'($urandom_range(300, 511)));
      run_frame("random", lv, q, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
Downstream consumer of the ripple-carry adder stage. Takes the adder's DATA_WIDTH+1-bit sum (carry included) over a valid/ready handshake and accumulates a frame of `len` samples into a wider register. It then presents the frame total, with a sticky overflow flag, on an output valid/ready handshake. This is accumulate-and-dump, used for block sums and averaging.

Parameters:
DATA_WIDTH, 8, width of adder operands; in_sum is DATA_WIDTH+1 bits.
ACC_WIDTH, 16, accumulator width; must be >= DATA_WIDTH+1 (elaboration-time assertion).
MAX_LEN, 16, maximum samples per frame; CNT_W = $clog2(MAX_LEN+1).
SATURATE, 0, 1 = clamp at all-ones on overflow, 0 = wrap modulo 2^ACC_WIDTH.

Ports:
clk  in  1  single clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  upstream sum valid.
in_ready  out  1  block can accept a sample.
in_sum  in  DATA_WIDTH+1  adder result, zero-extended into the accumulator.
len  in  CNT_W  frame length; sampled only on the first accepted sample of a frame.
out_valid  out  1  frame result available.
out_ready  in  1  downstream accepts result.
out_acc  out  ACC_WIDTH  accumulated total (accumulator register).
out_count  out  CNT_W  samples in the frame.
out_ovf  out  1  sticky: at least one add in this frame exceeded ACC_WIDTH.

Behaviour:
- Reset values: state=IDLE, accumulator=0, count=0, target=0, out_ovf=0, out_valid=0, in_ready=0 while rst is high. in_ready=1 is permitted from the first cycle after rst deasserts.
- All outputs come directly from registers or state decode. No combinational path from in_* to out_*, or from out_ready to in_ready.
- Accept rules: input accept = in_valid && in_ready. Output accept = out_valid && out_ready.
- Target length: target = len, except len==0 gives 1 and len>MAX_LEN gives MAX_LEN.
- IDLE state:
  - in_ready=1, out_valid=0.
  - On accept: accumulator <= zext(in_sum), count <= 1, ovf <= 0, target latched.
  - Next state is HOLD if target==1, otherwise ACCUM.
- ACCUM state:
  - in_ready=1.
  - Each accept: accumulator <= accumulator + zext(in_sum) as an ACC_WIDTH+1-bit add, count++.
  - If the carry out is set: ovf <= 1. The accumulator gets all-ones if SATURATE, otherwise the low ACC_WIDTH bits.
  - Once saturated, further adds keep all-ones.
  - When count+1 == target on an accept, next state is HOLD.
  - Cycles with in_valid=0 are idle; there is no timeout.
- HOLD state:
  - in_ready=0, out_valid=1. out_acc, out_count and out_ovf stay stable.
  - On output accept, next state is IDLE. One bubble cycle follows before the next frame's first sample can be accepted.
- Latency: out_valid rises the cycle after the final sample is accepted.
- out_acc, out_count and out_ovf are meaningful only when out_valid=1. Between frames they track the live registers.
- len changes mid-frame are ignored.
- Asynchronous reset mid-frame or in HOLD discards the partial or undelivered result immediately, with no output handshake.
- Simultaneous events cannot occur in this design: input and output accepts never happen in the same cycle because HOLD forces in_ready=0.

Decomposition:
- Package sum_acc_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t;
  - a function clamp_len(len, MAX_LEN).
- Sub-module sat_add (combinational, parameterised ACC_WIDTH and SATURATE) produces {sum, ovf}. The main block holds the FSM, the counters and the registers.

Test Plan:
1. Basic frame (defaults), len=4, in_sum 10,20,30,40 back-to-back → out_valid 1 cycle after the 4th accept; out_acc=100, out_count=4, out_ovf=0.
2. Carry bit carried through, len=2, in_sum=9'h1FE twice → out_acc=1020, out_ovf=0.
3. Overflow, ACC_WIDTH=10, len=3, in_sum 511 ×3:
   - SATURATE=1 → out_acc=1023, out_ovf=1.
   - SATURATE=0 → out_acc=509, out_ovf=1.
4. Backpressure: hold out_ready=0 for 5 cycles in HOLD while pulsing in_valid → out_valid and all outputs held, in_ready=0, no samples consumed. Then raise out_ready → IDLE next cycle, in_ready=1, and the next frame with len=1, in_sum=7 gives out_acc=7.
5. Reset mid-frame: assert rst after 2 of 4 samples → all outputs 0 asynchronously. Then a new frame len=2 with sums 1,2 → out_acc=3, out_count=2.
6. Length clamping and latch:
   - len=0 with in_sum=5 → out_acc=5, out_count=1.
   - len=20 with sixteen samples of 1 → out_count=16, out_acc=16.
   - Changing len mid-frame has no effect.
